// File: rtl/dcache_data_arbiter.sv
// Shares the single-port dcache data SRAM between refill bursts, stores and loads.
// The grant is decided in the same cycle as the request, and a load's data returns one cycle after its grant.
module dcache_data_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_WORDS    = 256,
    parameter int LINE_WORDS   = 4,
    parameter int STARVE_LIMIT = 4,
    localparam int AW = $clog2(NUM_WORDS),
    localparam int LW = $clog2(LINE_WORDS),
    localparam int BW = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // refill path
    input  logic                  rf_valid_i,
    input  logic [AW-LW-1:0]      rf_line_i,
    input  logic [DATA_WIDTH-1:0] rf_wdata_i,
    output logic                  rf_ready_o,
    output logic                  rf_done_o,
    // store path
    input  logic                  st_req_i,
    input  logic [AW-1:0]         st_addr_i,
    input  logic [BW-1:0]         st_be_i,
    input  logic [DATA_WIDTH-1:0] st_wdata_i,
    output logic                  st_gnt_o,
    // load path
    input  logic                  ld_req_i,
    input  logic [AW-1:0]         ld_addr_i,
    output logic                  ld_gnt_o,
    output logic                  ld_rvalid_o,
    output logic [DATA_WIDTH-1:0] ld_rdata_o,
    // data store SRAM
    output logic                  ds_en_o,
    output logic                  ds_we_o,
    output logic [BW-1:0]         ds_be_o,
    output logic [AW-1:0]         ds_addr_o,
    output logic [DATA_WIDTH-1:0] ds_wdata_o,
    input  logic [DATA_WIDTH-1:0] ds_rdata_i
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [LW-1:0] LAST_BEAT  = LW'(LINE_WORDS - 1);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] REFILL = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [LW-1:0] beat_cnt_q, beat_cnt_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          ld_rvalid_q;
    logic          rf_done_q, rf_done_d;

    logic in_idle;
    logic rf_fire;
    logic ld_boost;
    logic st_win;
    logic ld_win;
    logic last_beat;

    // Refill is never back-pressured, so every valid beat is written immediately.
    assign in_idle    = (state_q == IDLE);
    assign rf_ready_o = 1'b1;
    assign rf_fire    = rf_valid_i;
    assign last_beat  = (beat_cnt_q == LAST_BEAT);

    // A load that has lost to stores STARVE_LIMIT times in a row overtakes the store.
    assign ld_boost = ld_req_i && (starve_cnt_q == STARVE_MAX);
    assign st_win   = in_idle && !rf_fire && st_req_i && !ld_boost;
    assign ld_win   = in_idle && !rf_fire && ld_req_i && (!st_req_i || ld_boost);

    assign st_gnt_o    = st_win;
    assign ld_gnt_o    = ld_win;
    assign ld_rvalid_o = ld_rvalid_q;
    assign ld_rdata_o  = ld_rvalid_q ? ds_rdata_i : '0;
    assign rf_done_o   = rf_done_q;

    always_comb begin
        ds_en_o    = 1'b0;
        ds_we_o    = 1'b0;
        ds_be_o    = '0;
        ds_addr_o  = '0;
        ds_wdata_o = '0;
        if (rf_fire) begin
            ds_en_o    = 1'b1;
            ds_we_o    = 1'b1;
            ds_be_o    = '1;
            ds_addr_o  = {rf_line_i, beat_cnt_q};
            ds_wdata_o = rf_wdata_i;
        end else if (st_win) begin
            ds_en_o    = 1'b1;
            ds_we_o    = 1'b1;
            ds_be_o    = st_be_i;
            ds_addr_o  = st_addr_i;
            ds_wdata_o = st_wdata_i;
        end else if (ld_win) begin
            ds_en_o   = 1'b1;
            ds_addr_o = ld_addr_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        rf_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rf_fire) begin
                    beat_cnt_d = LW'(1);
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                if (rf_fire) begin
                    if (last_beat) begin
                        beat_cnt_d = '0;
                        state_d    = IDLE;
                        rf_done_d  = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LW'(1);
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    // Only store-won cycles count as starvation; refill cycles leave the count untouched.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (ld_win) begin
            starve_cnt_d = '0;
        end else if (st_win && ld_req_i && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            starve_cnt_q <= '0;
            ld_rvalid_q  <= 1'b0;
            rf_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            ld_rvalid_q  <= ld_win;
            rf_done_q    <= rf_done_d;
        end
    end

endmodule

// File: tb/tb_dcache_data_arbiter.sv
// Directed bench for dcache_data_arbiter with a behavioural single-port SRAM attached to the ds_* port.
module tb_dcache_data_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        rf_valid_i = 1'b0;
    logic [5:0]  rf_line_i = '0;
    logic [31:0] rf_wdata_i = '0;
    logic        rf_ready_o, rf_done_o;
    logic        st_req_i = 1'b0;
    logic [7:0]  st_addr_i = '0;
    logic [3:0]  st_be_i = '0;
    logic [31:0] st_wdata_i = '0;
    logic        st_gnt_o;
    logic        ld_req_i = 1'b0;
    logic [7:0]  ld_addr_i = '0;
    logic        ld_gnt_o, ld_rvalid_o;
    logic [31:0] ld_rdata_o;
    logic        ds_en_o, ds_we_o;
    logic [3:0]  ds_be_o;
    logic [7:0]  ds_addr_o;
    logic [31:0] ds_wdata_o;
    logic [31:0] ds_rdata_i = '0;

    int total = 0;
    int bad = 0;

    logic [31:0] sram [0:255];

    dcache_data_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .rf_valid_i(rf_valid_i), .rf_line_i(rf_line_i), .rf_wdata_i(rf_wdata_i),
        .rf_ready_o(rf_ready_o), .rf_done_o(rf_done_o),
        .st_req_i(st_req_i), .st_addr_i(st_addr_i), .st_be_i(st_be_i),
        .st_wdata_i(st_wdata_i), .st_gnt_o(st_gnt_o),
        .ld_req_i(ld_req_i), .ld_addr_i(ld_addr_i), .ld_gnt_o(ld_gnt_o),
        .ld_rvalid_o(ld_rvalid_o), .ld_rdata_o(ld_rdata_o),
        .ds_en_o(ds_en_o), .ds_we_o(ds_we_o), .ds_be_o(ds_be_o),
        .ds_addr_o(ds_addr_o), .ds_wdata_o(ds_wdata_o), .ds_rdata_i(ds_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (ds_en_o) begin
            if (ds_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (ds_be_o[b]) sram[ds_addr_o][8*b +: 8] <= ds_wdata_o[8*b +: 8];
            end else begin
                ds_rdata_i <= sram[ds_addr_o];
            end
        end
    end

    task automatic do_store(input logic [7:0] addr, input logic [3:0] be, input logic [31:0] data);
        bit got = 0;
        @(posedge clk_i); #1;
        st_req_i = 1'b1; st_addr_i = addr; st_be_i = be; st_wdata_i = data;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk_i);
            if (st_gnt_o === 1'b1) got = 1;
            else begin @(posedge clk_i); #1; end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL store_grant_timeout addr=%0d", addr);
        end
        @(posedge clk_i); #1;
        st_req_i = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] addr, output logic [31:0] data, output bit ok);
        bit got = 0;
        @(posedge clk_i); #1;
        ld_req_i = 1'b1; ld_addr_i = addr;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk_i);
            if (ld_gnt_o === 1'b1) got = 1;
            else begin @(posedge clk_i); #1; end
        end
        @(posedge clk_i); #1;
        ld_req_i = 1'b0;
        @(negedge clk_i);
        ok = got && (ld_rvalid_o === 1'b1);
        data = ld_rdata_o;
    endtask

    task automatic test_reset();
        @(posedge clk_i); #1;
        @(negedge clk_i);
        total++;
        if ({ld_rvalid_o, rf_done_o, ds_en_o, st_gnt_o, ld_gnt_o} !== 5'b0 || ld_rdata_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs got rv=%b done=%b en=%b sg=%b lg=%b rd=%h want all 0",
                     ld_rvalid_o, rf_done_o, ds_en_o, st_gnt_o, ld_gnt_o, ld_rdata_o);
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        total++;
        if (rf_ready_o !== 1'b1 || ds_en_o !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset got ready=%b en=%b want 1 0", rf_ready_o, ds_en_o);
        end
        $display("test_reset: done");
    endtask

    task automatic test_load();
        logic [31:0] d;
        do_store(8'd5, 4'hF, 32'hDEADBEEF);
        @(posedge clk_i); #1;
        ld_req_i = 1'b1; ld_addr_i = 8'd5;
        @(negedge clk_i);
        total++;
        if (ld_gnt_o !== 1'b1 || ds_en_o !== 1'b1 || ds_we_o !== 1'b0 || ds_addr_o !== 8'd5) begin
            bad++;
            $display("FAIL load_issue got gnt=%b en=%b we=%b addr=%0d want 1 1 0 5",
                     ld_gnt_o, ds_en_o, ds_we_o, ds_addr_o);
        end
        @(posedge clk_i); #1;
        ld_req_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (ld_rvalid_o !== 1'b1 || ld_rdata_o !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL load_data got rv=%b rd=%h want 1 deadbeef", ld_rvalid_o, ld_rdata_o);
        end
        @(posedge clk_i); #1;
        @(negedge clk_i);
        total++;
        if (ld_rvalid_o !== 1'b0 || ld_rdata_o !== 32'h0) begin
            bad++;
            $display("FAIL load_idle got rv=%b rd=%h want 0 0", ld_rvalid_o, ld_rdata_o);
        end
        d = 32'h0;
        $display("test_load: addr 5 done %h", d);
    endtask

    task automatic test_store_load_same();
        @(posedge clk_i); #1;
        st_req_i = 1'b1; st_addr_i = 8'd7; st_be_i = 4'hF; st_wdata_i = 32'h11223344;
        ld_req_i = 1'b1; ld_addr_i = 8'd7;
        @(negedge clk_i);
        total++;
        if (st_gnt_o !== 1'b1 || ld_gnt_o !== 1'b0 || ds_we_o !== 1'b1 || ds_wdata_o !== 32'h11223344) begin
            bad++;
            $display("FAIL sl_cycle0 got sg=%b lg=%b we=%b wd=%h want 1 0 1 11223344",
                     st_gnt_o, ld_gnt_o, ds_we_o, ds_wdata_o);
        end
        @(posedge clk_i); #1;
        st_req_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (ld_gnt_o !== 1'b1 || st_gnt_o !== 1'b0) begin
            bad++;
            $display("FAIL sl_cycle1 got lg=%b sg=%b want 1 0", ld_gnt_o, st_gnt_o);
        end
        @(posedge clk_i); #1;
        ld_req_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (ld_rvalid_o !== 1'b1 || ld_rdata_o !== 32'h11223344) begin
            bad++;
            $display("FAIL sl_cycle2 got rv=%b rd=%h want 1 11223344", ld_rvalid_o, ld_rdata_o);
        end
        $display("test_store_load_same: done");
    endtask

    task automatic test_refill();
        logic [31:0] beat_dat [5];
        bit          beat_v   [5];
        logic [31:0] exp_dat  [4];
        logic [31:0] d;
        bit ok;
        int w = 0;
        beat_dat = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'h0, 32'hC2C2C2C2, 32'hD3D3D3D3};
        beat_v   = '{1, 1, 0, 1, 1};
        exp_dat  = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i); #1;
            ld_req_i = 1'b1; ld_addr_i = 8'd5;
            rf_line_i = 6'd3; rf_valid_i = beat_v[c]; rf_wdata_i = beat_dat[c];
            @(negedge clk_i);
            total++;
            if (ld_gnt_o !== 1'b0 || rf_done_o !== 1'b0 || rf_ready_o !== 1'b1) begin
                bad++;
                $display("FAIL refill_block c=%0d got lg=%b done=%b rdy=%b want 0 0 1",
                         c, ld_gnt_o, rf_done_o, rf_ready_o);
            end
            if (beat_v[c]) begin
                total++;
                if (ds_en_o !== 1'b1 || ds_we_o !== 1'b1 || ds_be_o !== 4'hF || ds_addr_o !== 8'(12 + w)) begin
                    bad++;
                    $display("FAIL refill_write c=%0d got en=%b we=%b be=%h addr=%0d want 1 1 f %0d",
                             c, ds_en_o, ds_we_o, ds_be_o, ds_addr_o, 12 + w);
                end
                w++;
            end else begin
                total++;
                if (ds_en_o !== 1'b0) begin
                    bad++;
                    $display("FAIL refill_bubble got en=%b want 0", ds_en_o);
                end
            end
        end
        @(posedge clk_i); #1;
        rf_valid_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (rf_done_o !== 1'b1 || ld_gnt_o !== 1'b1) begin
            bad++;
            $display("FAIL refill_done got done=%b lg=%b want 1 1", rf_done_o, ld_gnt_o);
        end
        @(posedge clk_i); #1;
        ld_req_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (rf_done_o !== 1'b0) begin
            bad++;
            $display("FAIL refill_done_pulse got done=%b want 0", rf_done_o);
        end
        for (int i = 0; i < 4; i++) begin
            do_load(8'(12 + i), d, ok);
            total++;
            if (!ok || d !== exp_dat[i]) begin
                bad++;
                $display("FAIL refill_readback word=%0d got ok=%b rd=%h want %h", 12 + i, ok, d, exp_dat[i]);
            end
        end
        $display("test_refill: line 3 done");
    endtask

    task automatic test_starvation();
        bit exp_st [6];
        exp_st = '{1, 1, 1, 1, 0, 1};
        @(posedge clk_i); #1;
        st_req_i = 1'b1; st_addr_i = 8'd20; st_be_i = 4'hF; st_wdata_i = 32'h5A5A5A5A;
        ld_req_i = 1'b1; ld_addr_i = 8'd21;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin @(posedge clk_i); #1; end
            if (c == 5) ld_req_i = 1'b0;
            @(negedge clk_i);
            total++;
            if (st_gnt_o !== exp_st[c] || (c < 5 && ld_gnt_o !== !exp_st[c])) begin
                bad++;
                $display("FAIL starve c=%0d got sg=%b lg=%b want sg=%b", c, st_gnt_o, ld_gnt_o, exp_st[c]);
            end
        end
        @(posedge clk_i); #1;
        st_req_i = 1'b0;
        $display("test_starvation: done");
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] d;
        bit ok;
        for (int b = 0; b < 2; b++) begin
            @(posedge clk_i); #1;
            rf_valid_i = 1'b1; rf_line_i = 6'd2; rf_wdata_i = 32'h80000000 | b;
        end
        @(posedge clk_i); #1;
        rf_valid_i = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk_i);
        total++;
        if (ld_rvalid_o !== 1'b0 || rf_done_o !== 1'b0 || ds_en_o !== 1'b0) begin
            bad++;
            $display("FAIL midreset_outputs got rv=%b done=%b en=%b want 0 0 0", ld_rvalid_o, rf_done_o, ds_en_o);
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        for (int b = 0; b < 4; b++) begin
            @(posedge clk_i); #1;
            rf_valid_i = 1'b1; rf_line_i = 6'd1; rf_wdata_i = 32'h40000000 | b;
            @(negedge clk_i);
            total++;
            if (ds_addr_o !== 8'(4 + b) || ds_we_o !== 1'b1 || rf_done_o !== 1'b0) begin
                bad++;
                $display("FAIL midreset_refill beat=%0d got addr=%0d we=%b done=%b want %0d 1 0",
                         b, ds_addr_o, ds_we_o, rf_done_o, 4 + b);
            end
        end
        @(posedge clk_i); #1;
        rf_valid_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (rf_done_o !== 1'b1) begin
            bad++;
            $display("FAIL midreset_done got done=%b want 1", rf_done_o);
        end
        do_load(8'd9, d, ok);
        total++;
        if (!ok || d !== 32'h80000001) begin
            bad++;
            $display("FAIL midreset_kept got ok=%b rd=%h want 80000001", ok, d);
        end
        do_load(8'd7, d, ok);
        total++;
        if (!ok || d !== 32'h40000003) begin
            bad++;
            $display("FAIL midreset_word7 got ok=%b rd=%h want 40000003", ok, d);
        end
        $display("test_reset_mid_refill: done");
    endtask

    task automatic test_byte_store();
        logic [31:0] d;
        bit ok;
        do_store(8'd9, 4'hF, 32'hAAAAAAAA);
        @(posedge clk_i); #1;
        st_req_i = 1'b1; st_addr_i = 8'd9; st_be_i = 4'b0101; st_wdata_i = 32'h12345678;
        @(negedge clk_i);
        total++;
        if (st_gnt_o !== 1'b1 || ds_be_o !== 4'b0101 || ds_addr_o !== 8'd9) begin
            bad++;
            $display("FAIL byte_store_issue got sg=%b be=%b addr=%0d want 1 0101 9", st_gnt_o, ds_be_o, ds_addr_o);
        end
        @(posedge clk_i); #1;
        st_be_i = 4'b0000; st_wdata_i = 32'hFFFFFFFF;
        @(negedge clk_i);
        total++;
        if (st_gnt_o !== 1'b1 || ds_en_o !== 1'b1 || ds_be_o !== 4'b0000) begin
            bad++;
            $display("FAIL zero_be_store got sg=%b en=%b be=%b want 1 1 0000", st_gnt_o, ds_en_o, ds_be_o);
        end
        @(posedge clk_i); #1;
        st_req_i = 1'b0;
        do_load(8'd9, d, ok);
        total++;
        if (!ok || d !== 32'hAA34AA78) begin
            bad++;
            $display("FAIL byte_store_readback got ok=%b rd=%h want aa34aa78", ok, d);
        end
        $display("test_byte_store: done");
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_load_same();
        test_refill();
        test_starvation();
        test_reset_mid_refill();
        test_byte_store();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
